// File: rtl/load_controller_pkg.sv
// Shared FSM state encoding and default timing parameters for the load controller.
package load_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DEB_PRESS = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_DEB_REL   = 2'd3
    } state_t;

    localparam int DEF_DATA_W      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_CYCLES  = 16;

endpackage

// File: rtl/load_controller_sync_ff.sv
// Single-bit multi-stage synchroniser for asynchronous inputs; clears to 0 on reset.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/load_controller.sv
// Turns a bouncing push-button and raw switches into one clean Load strobe with a
// stable Data word; the debounce FSM accepts one load per physical press.
module load_controller
    import load_controller_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              Btn,
    input  logic [DATA_W-1:0] Sw,
    output logic              Load,
    output logic [DATA_W-1:0] Data,
    output logic              Busy,
    output state_t            o_dbg_state
);

    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic              w_btn_s;
    logic [DATA_W-1:0] w_sw_s;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_load;
    logic [DATA_W-1:0] r_data;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_btn (
        .i_clk   (CLK),
        .i_rst_n (RST_n),
        .i_d     (Btn),
        .o_q     (w_btn_s)
    );

    for (genvar g = 0; g < DATA_W; g++) begin : g_sw_sync
        sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sw (
            .i_clk   (CLK),
            .i_rst_n (RST_n),
            .i_d     (Sw[g]),
            .o_q     (w_sw_s[g])
        );
    end

    // Load defaults low every cycle so it can only pulse on the accepting edge.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_load  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_btn_s) begin
                        r_state <= ST_DEB_PRESS;
                        r_cnt   <= CNT_ONE;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!w_btn_s) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_PRESSED;
                        r_load  <= 1'b1;
                        r_data  <= w_sw_s;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!w_btn_s) begin
                        r_state <= ST_DEB_REL;
                        r_cnt   <= CNT_ONE;
                    end
                end
                ST_DEB_REL: begin
                    if (w_btn_s) begin
                        r_state <= ST_PRESSED;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Load        = r_load;
    assign Data        = r_data;
    assign Busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_load_controller.sv
// Directed bench for load_controller: every accepted press pushes its expected
// Data and Load edge; each observed Load pops and compares them.
module tb_load_controller;
    import load_controller_pkg::*;

    localparam int DATA_W  = 4;
    localparam int LATENCY = 18;

    logic              CLK   = 1'b0;
    logic              RST_n = 1'b0;
    logic              Btn   = 1'b0;
    logic [DATA_W-1:0] Sw    = '0;
    logic              Load;
    logic [DATA_W-1:0] Data;
    logic              Busy;
    state_t            dbg_state;

    int checks   = 0;
    int errors   = 0;
    int edge_n   = 0;
    int load_cnt = 0;
    int rise_edge;

    logic [DATA_W-1:0] exp_q[$];
    int                exp_edge_q[$];

    load_controller #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .DEB_CYCLES  (16)
    ) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .Btn         (Btn),
        .Sw          (Sw),
        .Load        (Load),
        .Data        (Data),
        .Busy        (Busy),
        .o_dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_load(input logic [DATA_W-1:0] d);
        exp_q.push_back(d);
        exp_edge_q.push_back(edge_n + LATENCY);
    endtask

    // One rising edge, then observe on the falling edge and score any Load.
    task automatic tick();
        logic [DATA_W-1:0] d;
        int                e;
        @(posedge CLK);
        @(negedge CLK);
        edge_n++;
        if (Load !== 1'b0) begin
            load_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_load", {31'd0, Load}, 32'd0);
            end else begin
                d = exp_q.pop_front();
                e = exp_edge_q.pop_front();
                check("load_data", {28'd0, Data}, {28'd0, d});
                check("load_edge", edge_n, e);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic release_and_check_idle(input string tag);
        Btn = 1'b0;
        ticks(LATENCY - 1);
        check({tag, "_busy_rel"}, {31'd0, Busy}, 32'd1);
        tick();
        check({tag, "_busy_idle"}, {31'd0, Busy}, 32'd0);
        check({tag, "_state_idle"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
    endtask

    initial begin
        // Reset held with button pressed and switches all ones.
        RST_n = 1'b0;
        Btn   = 1'b1;
        Sw    = 4'hF;
        ticks(3);
        check("rst_load", {31'd0, Load}, 32'd0);
        check("rst_data", {28'd0, Data}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        RST_n = 1'b1;
        expect_load(4'hF);
        ticks(40);
        release_and_check_idle("rst_press");
        check("rst_press_done", exp_q.size(), 0);

        // Clean press.
        Sw = 4'h5;
        ticks(4);
        Btn = 1'b1;
        expect_load(4'h5);
        ticks(40);
        check("clean_data", {28'd0, Data}, 32'h5);
        check("clean_busy", {31'd0, Busy}, 32'd1);
        release_and_check_idle("clean");
        check("clean_data_hold", {28'd0, Data}, 32'h5);
        check("clean_done", exp_q.size(), 0);

        // Bounce: toggle every 3 cycles for 30 cycles, then hold high.
        Sw = 4'h9;
        ticks(4);
        for (int i = 0; i < 10; i++) begin
            Btn = (i % 2 == 0);
            ticks(3);
        end
        check("bounce_no_load", exp_q.size(), 0);
        check("bounce_data_old", {28'd0, Data}, 32'h5);
        Btn = 1'b1;
        rise_edge = edge_n;
        expect_load(4'h9);
        ticks(40);
        check("bounce_edge_base", exp_edge_q.size(), 0);
        release_and_check_idle("bounce");

        // Long hold, then 4-cycle low glitches on release.
        Sw = 4'hA;
        ticks(4);
        Btn = 1'b1;
        expect_load(4'hA);
        ticks(200);
        for (int i = 0; i < 2; i++) begin
            Btn = 1'b0;
            ticks(4);
            Btn = 1'b1;
            ticks(2);
        end
        check("long_busy_glitch", {31'd0, Busy}, 32'd1);
        release_and_check_idle("long");
        check("long_done", exp_q.size(), 0);

        // Switch isolation between presses.
        Sw = 4'h3;
        ticks(4);
        Btn = 1'b1;
        expect_load(4'h3);
        ticks(30);
        release_and_check_idle("sw3");
        Sw = 4'hC;
        ticks(10);
        check("sw_isolation", {28'd0, Data}, 32'h3);
        Btn = 1'b1;
        expect_load(4'hC);
        ticks(30);
        check("sw_second", {28'd0, Data}, 32'hC);
        release_and_check_idle("swC");

        // Async reset in the middle of a press debounce.
        Sw  = 4'h6;
        Btn = 1'b1;
        ticks(10);
        check("mid_busy", {31'd0, Busy}, 32'd1);
        RST_n = 1'b0;
        #1;
        check("mid_rst_load", {31'd0, Load}, 32'd0);
        check("mid_rst_data", {28'd0, Data}, 32'd0);
        check("mid_rst_busy", {31'd0, Busy}, 32'd0);
        check("mid_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        Btn = 1'b0;
        ticks(3);
        RST_n = 1'b1;
        ticks(30);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_load_count", load_cnt, 6);
        check("final_data_reset", {28'd0, Data}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
